// File: rtl/blink_if.sv
// LED drive interface: the blinker sources the active-low red LED pin,
// the board side consumes it.
interface blink_if;
   logic nLED_RED;

   modport master (output nLED_RED);
   modport slave  (input  nLED_RED);
endinterface

// File: rtl/blink_top.sv
// Red LED blinker: a prescaler makes a millisecond tick, a millisecond counter
// flips the on/off phase every TOGGLE_MS, and an 8-bit PWM dims the on-phase.
module blink_top #(
   parameter int CLK_FREQ_HZ = 12_000_000,
   parameter int TOGGLE_MS   = 10,
   parameter int DUTY        = 256
) (
   input  logic     clk,
   input  logic     rst_n,
   blink_if.master  led_if
);
   localparam int          DIV        = CLK_FREQ_HZ / 1000;
   localparam int          PW         = $clog2(DIV);
   localparam int          MW         = $clog2(TOGGLE_MS + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
   localparam logic [MW-1:0] MS_MAX    = MW'(TOGGLE_MS - 1);
   localparam logic [8:0]  DUTY_9     = 9'(DUTY);

   logic [PW-1:0] presc_q,   presc_d;
   logic [MW-1:0] ms_q,      ms_d;
   logic          phase_q,   phase_d;
   logic [7:0]    pwm_cnt_q, pwm_cnt_d;
   logic          nled_q,    nled_d;
   logic          ms_tick_s;
   logic          led_on_s;

   // Next-state for all counters; every wrap is evaluated independently so
   // coincident wraps all land on the same edge.
   always_comb begin
      ms_tick_s = (presc_q == PRESC_MAX);
      presc_d   = presc_q + PW'(1);
      ms_d      = ms_q;
      phase_d   = phase_q;
      if (ms_tick_s) begin
         presc_d = '0;
         if (ms_q == MS_MAX) begin
            ms_d    = '0;
            phase_d = ~phase_q;
         end else begin
            ms_d    = ms_q + MW'(1);
         end
      end else begin
         presc_d = presc_q + PW'(1);
      end
      pwm_cnt_d = pwm_cnt_q + 8'd1;
      // 9-bit compare so DUTY = 256 keeps the LED solidly lit
      led_on_s  = phase_q & ({1'b0, pwm_cnt_q} < DUTY_9);
      nled_d    = ~led_on_s;
   end

   // State registers; the pin flop resets high so the LED is dark in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= '0;
         ms_q      <= '0;
         phase_q   <= 1'b0;
         pwm_cnt_q <= 8'd0;
         nled_q    <= 1'b1;
      end else begin
         presc_q   <= presc_d;
         ms_q      <= ms_d;
         phase_q   <= phase_d;
         pwm_cnt_q <= pwm_cnt_d;
         nled_q    <= nled_d;
      end
   end

   assign led_if.nLED_RED = nled_q;
endmodule

// File: tb/tb_blink_top.sv
// Scoreboard bench for blink_top: five scaled configurations share clock and
// reset; expected pin values come from a closed-form timing model.
module tb_blink_top;
   localparam int NI = 5;
   localparam int DIV_T [NI] = '{4, 256, 256, 2, 12};
   localparam int TOG_T [NI] = '{2, 2,   2,   1, 3};
   localparam int DUTY_T[NI] = '{256, 128, 0, 256, 200};

   typedef struct {
      int   idx;
      logic val;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n = 0;
   exp_t exp_q[$];
   logic [NI-1:0] obs;

   blink_if if_a ();
   blink_if if_b ();
   blink_if if_c ();
   blink_if if_d ();
   blink_if if_e ();

   blink_top #(.CLK_FREQ_HZ(4000),   .TOGGLE_MS(2), .DUTY(256)) u_a (.clk(clk), .rst_n(rst_n), .led_if(if_a));
   blink_top #(.CLK_FREQ_HZ(256000), .TOGGLE_MS(2), .DUTY(128)) u_b (.clk(clk), .rst_n(rst_n), .led_if(if_b));
   blink_top #(.CLK_FREQ_HZ(256000), .TOGGLE_MS(2), .DUTY(0))   u_c (.clk(clk), .rst_n(rst_n), .led_if(if_c));
   blink_top #(.CLK_FREQ_HZ(2000),   .TOGGLE_MS(1), .DUTY(256)) u_d (.clk(clk), .rst_n(rst_n), .led_if(if_d));
   blink_top #(.CLK_FREQ_HZ(12000),  .TOGGLE_MS(3), .DUTY(200)) u_e (.clk(clk), .rst_n(rst_n), .led_if(if_e));

   assign obs = {if_e.nLED_RED, if_d.nLED_RED, if_c.nLED_RED, if_b.nLED_RED, if_a.nLED_RED};

   always #42 clk = ~clk;

   task automatic chk(input string tag, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // Pin value after rising edge k counted from reset release.
   function automatic logic exp_nled(input int k, input int div, input int tog, input int duty);
      int m;
      int ph;
      if (k == 0) return 1'b1;
      m  = k - 1;
      ph = (m / (div * tog)) % 2;
      return !((ph == 1) && ((m % 256) < duty));
   endfunction

   task automatic step();
      exp_t e;
      for (int i = 0; i < NI; i++) begin
         e.idx = i;
         e.val = exp_nled(n + 1, DIV_T[i], TOG_T[i], DUTY_T[i]);
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      n++;
      for (int i = 0; i < NI; i++) begin
         if (exp_q.size() == 0) begin
            chk("queue_empty", 0, 1);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("nled%0d_edge%0d", e.idx, n), int'(obs[e.idx]), int'(e.val));
         end
      end
   endtask

   task automatic check_reset_state();
      for (int i = 0; i < NI; i++) chk($sformatf("rst_nled%0d", i), int'(obs[i]), 1);
      chk("rst_presc", int'(u_a.presc_q), 0);
      chk("rst_ms", int'(u_a.ms_q), 0);
      chk("rst_pwm", int'(u_a.pwm_cnt_q), 0);
      chk("rst_phase", int'(u_a.phase_q), 0);
   endtask

   initial begin
      int first_a;
      int first_b;
      int low_b;
      int low_c;
      int found;

      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         check_reset_state();
      end
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;

      first_a = -1;
      low_b = 0;
      low_c = 0;
      for (int c = 0; c < 1500; c++) begin
         step();
         if (obs[0] == 1'b0 && first_a < 0) first_a = n;
         if (n >= 513 && n <= 1024 && obs[1] == 1'b0) low_b++;
         if (obs[2] == 1'b0) low_c++;
      end
      chk("first_fall_a", first_a, 9);
      chk("pwm128_low_cycles", low_b, 256);
      chk("duty0_low_cycles", low_c, 0);

      found = 0;
      for (int c = 0; c < 32 && found == 0; c++) begin
         step();
         if (obs[0] == 1'b0) found = 1;
      end
      chk("find_lit_a", found, 1);

      // Mid on-phase reset must darken the pin without a clock edge
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) chk($sformatf("async_rst_nled%0d", i), int'(obs[i]), 1);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check_reset_state();
      end
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;

      first_a = -1;
      first_b = -1;
      for (int c = 0; c < 600; c++) begin
         step();
         if (obs[0] == 1'b0 && first_a < 0) first_a = n;
         if (obs[1] == 1'b0 && first_b < 0) first_b = n;
      end
      chk("refall_a", first_a, 9);
      chk("relight_b", first_b, 513);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
